// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
// Sequencer for a 4-digit BCD frequency counter. Each measurement is:
//   CLEAR  (count_clear high for CLEAR_CYCLES)
//   GATE   (count_ena high for exactly gate_len cycles)
//   SETTLE (SETTLE_CYCLES idle cycles so the counter digits are static)
//   LATCH  (one cycle; digits and overflow captured at its closing edge)
// then back to IDLE, or straight into CLEAR again when auto_mode is held.
//
// Ports:
//   clk          reference time-base clock
//   rst_n        asynchronous active-low reset
//   start        one-shot measurement request, ignored while busy
//   auto_mode    1 = re-measure continuously
//   cnt3..cnt0   BCD digits from the counter
//   count_clear  counter clear, high only in CLEAR
//   count_ena    counter enable, high only in GATE
//   disp3..disp0 latched digits, held until the next latch or reset
//   overflow     latched flag: some digit read 4'hE at latch
//   done         one-cycle pulse in the cycle after each latch
//   busy         high in every state other than IDLE
//   range        (FREQ_GATE_CTRL_AUTORANGE_EN only) gate divider exponent,
//                gate_len = GATE_CYCLES / 10^range
//
// Optional feature macro: FREQ_GATE_CTRL_AUTORANGE_EN
// -----------------------------------------------------------------------------
module freq_gate_ctrl #(
   parameter int GATE_CYCLES   = 1000,
   parameter int CLEAR_CYCLES  = 1,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       auto_mode,
   input  logic [3:0] cnt3,
   input  logic [3:0] cnt2,
   input  logic [3:0] cnt1,
   input  logic [3:0] cnt0,
   output logic       count_clear,
   output logic       count_ena,
   output logic [3:0] disp3,
   output logic [3:0] disp2,
   output logic [3:0] disp1,
   output logic [3:0] disp0,
   output logic       overflow,
   output logic       done,
`ifdef FREQ_GATE_CTRL_AUTORANGE_EN
   output logic       busy,
   output logic [1:0] range
`else
   output logic       busy
`endif
);

   localparam int MAX_GC = (GATE_CYCLES > CLEAR_CYCLES) ? GATE_CYCLES : CLEAR_CYCLES;
   localparam int MAX_ALL = (MAX_GC > SETTLE_CYCLES) ? MAX_GC : SETTLE_CYCLES;
   localparam int TW = $clog2(MAX_ALL) + 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_GATE   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_LATCH  = 3'd4
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [TW-1:0] tcnt_r;
   logic [TW-1:0] tcnt_nxt_s;
   logic [TW-1:0] gate_len_s;
   logic          ovf_s;

   // A digit value of 4'hE is the counter's overflow marker.
   function automatic logic ovf_f(input logic [3:0] d3, input logic [3:0] d2,
                                  input logic [3:0] d1, input logic [3:0] d0);
      return (d3 == 4'hE) || (d2 == 4'hE) || (d1 == 4'hE) || (d0 == 4'hE);
   endfunction

   assign ovf_s = ovf_f(cnt3, cnt2, cnt1, cnt0);

`ifdef FREQ_GATE_CTRL_AUTORANGE_EN
   // Step up on overflow, step down when the leading digit is unused.
   function automatic logic [1:0] range_upd_f(input logic [1:0] r, input logic ovf,
                                              input logic [3:0] d3);
      logic [1:0] res;
      if (ovf && (r < 2'd2)) begin
         res = r + 2'd1;
      end else if ((d3 == 4'd0) && (r > 2'd0)) begin
         res = r - 2'd1;
      end else begin
         res = r;
      end
      return res;
   endfunction

   // Gate length shrinks by a decade per range step.
   always_comb begin
      gate_len_s = TW'(GATE_CYCLES);
      case (range)
         2'd0:    gate_len_s = TW'(GATE_CYCLES);
         2'd1:    gate_len_s = TW'(GATE_CYCLES / 10);
         2'd2:    gate_len_s = TW'(GATE_CYCLES / 100);
         default: gate_len_s = TW'(GATE_CYCLES);
      endcase
   end

   // Range register, updated only at the LATCH closing edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range <= 2'd0;
      end else if (state_r == ST_LATCH) begin
         range <= range_upd_f(range, ovf_s, cnt3);
      end
   end
`else
   assign gate_len_s = TW'(GATE_CYCLES);
`endif

   // Next-state and timer logic; tcnt is loaded with (duration-1) on entry.
   always_comb begin
      state_nxt_s = state_r;
      tcnt_nxt_s  = tcnt_r;
      case (state_r)
         ST_IDLE: begin
            if (start || auto_mode) begin
               state_nxt_s = ST_CLEAR;
               tcnt_nxt_s  = TW'(CLEAR_CYCLES - 1);
            end else begin
               state_nxt_s = ST_IDLE;
               tcnt_nxt_s  = tcnt_r;
            end
         end
         ST_CLEAR: begin
            if (tcnt_r == {TW{1'b0}}) begin
               state_nxt_s = ST_GATE;
               tcnt_nxt_s  = gate_len_s - TW'(1);
            end else begin
               state_nxt_s = ST_CLEAR;
               tcnt_nxt_s  = tcnt_r - TW'(1);
            end
         end
         ST_GATE: begin
            if (tcnt_r == {TW{1'b0}}) begin
               state_nxt_s = ST_SETTLE;
               tcnt_nxt_s  = TW'(SETTLE_CYCLES - 1);
            end else begin
               state_nxt_s = ST_GATE;
               tcnt_nxt_s  = tcnt_r - TW'(1);
            end
         end
         ST_SETTLE: begin
            if (tcnt_r == {TW{1'b0}}) begin
               state_nxt_s = ST_LATCH;
               tcnt_nxt_s  = {TW{1'b0}};
            end else begin
               state_nxt_s = ST_SETTLE;
               tcnt_nxt_s  = tcnt_r - TW'(1);
            end
         end
         ST_LATCH: begin
            // auto_mode is only consulted here, so dropping it mid-measurement
            // lets the current measurement finish.
            if (auto_mode) begin
               state_nxt_s = ST_CLEAR;
               tcnt_nxt_s  = TW'(CLEAR_CYCLES - 1);
            end else begin
               state_nxt_s = ST_IDLE;
               tcnt_nxt_s  = {TW{1'b0}};
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            tcnt_nxt_s  = {TW{1'b0}};
         end
      endcase
   end

   // State register with outputs registered from the next state, so they
   // line up exactly with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         tcnt_r      <= {TW{1'b0}};
         count_clear <= 1'b0;
         count_ena   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         tcnt_r      <= tcnt_nxt_s;
         count_clear <= (state_nxt_s == ST_CLEAR);
         count_ena   <= (state_nxt_s == ST_GATE);
         busy        <= (state_nxt_s != ST_IDLE);
         done        <= (state_r == ST_LATCH);
      end
   end

   // Display and overflow capture at the LATCH closing edge; held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp3    <= 4'd0;
         disp2    <= 4'd0;
         disp1    <= 4'd0;
         disp0    <= 4'd0;
         overflow <= 1'b0;
      end else if (state_r == ST_LATCH) begin
         disp3    <= cnt3;
         disp2    <= cnt2;
         disp1    <= cnt1;
         disp0    <= cnt0;
         overflow <= ovf_s;
      end
   end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
module tb_freq_gate_ctrl;

   localparam int GATE = 100;
   localparam int CLR  = 1;
   localparam int SET  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       auto_mode;
   logic [3:0] cnt3, cnt2, cnt1, cnt0;
   logic       count_clear, count_ena, overflow, done, busy;
   logic [3:0] disp3, disp2, disp1, disp0;
`ifdef FREQ_GATE_CTRL_AUTORANGE_EN
   logic [1:0] range;
`endif

   typedef struct {
      logic [3:0] d3, d2, d1, d0;
      logic       ovf;
      logic [1:0] rng;
   } exp_t;

   exp_t       sb[$];
   exp_t       last;
   logic [1:0] exp_range;
   int         n_assert = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   freq_gate_ctrl #(
      .GATE_CYCLES(GATE), .CLEAR_CYCLES(CLR), .SETTLE_CYCLES(SET)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .auto_mode(auto_mode),
      .cnt3(cnt3), .cnt2(cnt2), .cnt1(cnt1), .cnt0(cnt0),
      .count_clear(count_clear), .count_ena(count_ena),
      .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
      .overflow(overflow), .done(done),
`ifdef FREQ_GATE_CTRL_AUTORANGE_EN
      .busy(busy), .range(range)
`else
      .busy(busy)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int gate_of(input logic [1:0] r);
      int g;
      case (r)
         2'd1:    g = GATE / 10;
         2'd2:    g = GATE / 100;
         default: g = GATE;
      endcase
      return g;
   endfunction

   function automatic logic [1:0] next_range(input logic [1:0] r, input logic ovf,
                                             input logic [3:0] d3);
`ifdef FREQ_GATE_CTRL_AUTORANGE_EN
      if (ovf && r < 2'd2) return r + 2'd1;
      if (d3 == 4'd0 && r > 2'd0) return r - 2'd1;
      return r;
`else
      if (ovf && d3 == 4'hF) return r;
      return r;
`endif
   endfunction

   // Advance one clock, land on the falling edge for sampling.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [3:0] c3, input logic [3:0] c2,
                           input logic [3:0] c1, input logic [3:0] c0);
      exp_t e;
      e.d3 = c3; e.d2 = c2; e.d1 = c1; e.d0 = c0;
      e.ovf = (c3 == 4'hE) || (c2 == 4'hE) || (c1 == 4'hE) || (c0 == 4'hE);
      e.rng = next_range(exp_range, e.ovf, c3);
      exp_range = e.rng;
      sb.push_back(e);
   endtask

   // On a done pulse, pop the oldest expectation and compare the latched values.
   task automatic check_result();
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 8'(sb.size()), 8'd1);
         end else begin
            e = sb.pop_front();
            chk("disp3", 8'(disp3), 8'(e.d3));
            chk("disp2", 8'(disp2), 8'(e.d2));
            chk("disp1", 8'(disp1), 8'(e.d1));
            chk("disp0", 8'(disp0), 8'(e.d0));
            chk("overflow", 8'(overflow), 8'(e.ovf));
`ifdef FREQ_GATE_CTRL_AUTORANGE_EN
            chk("range", 8'(range), 8'(e.rng));
`endif
            last = e;
         end
      end
   endtask

   // One start-triggered measurement, traced cycle by cycle against edge 0.
   task automatic measure(input logic [3:0] c3, input logic [3:0] c2,
                          input logic [3:0] c1, input logic [3:0] c0, input int glitch);
      int g;
      g = gate_of(exp_range);
      cnt3 = c3; cnt2 = c2; cnt1 = c1; cnt0 = c0;
      push_exp(c3, c2, c1, c0);
      start = 1'b1;
      for (int c = 1; c <= g + 6; c++) begin
         step();
         if (c == 1) start = 1'b0;
         chk("count_clear", 8'(count_clear), 8'(c == 1));
         chk("count_ena", 8'(count_ena), 8'(c >= 2 && c <= g + 1));
         chk("busy", 8'(busy), 8'(c <= g + 4));
         chk("done", 8'(done), 8'(c == g + 5));
         check_result();
         if (glitch > 0 && c == glitch) start = 1'b1;
         else if (glitch > 0 && c == glitch + 1) start = 1'b0;
      end
   endtask

   initial begin
      int p_len;
      int g;
      int ph;
      exp_range = 2'd0;
      last = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0};
      rst_n = 1'b0; start = 1'b0; auto_mode = 1'b0;
      cnt3 = 4'd0; cnt2 = 4'd0; cnt1 = 4'd0; cnt0 = 4'd0;
      repeat (3) step();
      chk("rst_clear", 8'(count_clear), 8'd0);
      chk("rst_ena", 8'(count_ena), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_ovf", 8'(overflow), 8'd0);
      chk("rst_disp", 8'({disp3, disp2} | {disp1, disp0}), 8'd0);
`ifdef FREQ_GATE_CTRL_AUTORANGE_EN
      chk("rst_range", 8'(range), 8'd0);
`endif
      rst_n = 1'b1;
      step();

      // Basic measurement with a start pulse injected mid-gate (must be ignored).
      measure(4'd1, 4'd2, 4'd3, 4'd4, 50);
      for (int i = 0; i < 50; i++) begin
         step();
         chk("hold_busy", 8'(busy), 8'd0);
         chk("hold_disp", 8'({disp3, disp2}), 8'({last.d3, last.d2}));
         chk("hold_disp_lo", 8'({disp1, disp0}), 8'({last.d1, last.d0}));
         chk("hold_ovf", 8'(overflow), 8'(last.ovf));
      end

      // Overflow set, then cleared, then range walk up/saturate/down.
      measure(4'd5, 4'hE, 4'd0, 4'd9, 0);
      measure(4'd7, 4'd3, 4'd2, 4'd1, 0);
      measure(4'hE, 4'd0, 4'd0, 4'd0, 0);
      measure(4'd1, 4'd1, 4'hE, 4'd1, 0);
      measure(4'd0, 4'd1, 4'd2, 4'd3, 0);
      measure(4'd0, 4'd0, 4'd0, 4'd0, 0);

      // Continuous mode: three back-to-back measurements, auto_mode dropped mid-gate.
      g = gate_of(exp_range);
      p_len = g + 4;
      cnt3 = 4'd9; cnt2 = 4'd8; cnt1 = 4'd7; cnt0 = 4'd6;
      for (int k = 0; k < 3; k++) push_exp(4'd9, 4'd8, 4'd7, 4'd6);
      auto_mode = 1'b1;
      for (int c = 1; c <= 3 * p_len + 5; c++) begin
         step();
         ph = (c - 1) % p_len;
         chk("auto_clear", 8'(count_clear), 8'(c <= 3 * p_len && ph == 0));
         chk("auto_ena", 8'(count_ena), 8'(c <= 3 * p_len && ph >= 1 && ph <= g));
         chk("auto_busy", 8'(busy), 8'(c <= 3 * p_len));
         chk("auto_done", 8'(done), 8'(c > 1 && ph == 0 && c <= 3 * p_len + 1));
         check_result();
         if (c == 2 * p_len + 50) auto_mode = 1'b0;
      end

      // Asynchronous reset in the middle of a gate.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (49) step();
      chk("pre_rst_ena", 8'(count_ena), 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ena", 8'(count_ena), 8'd0);
      chk("arst_clear", 8'(count_clear), 8'd0);
      chk("arst_busy", 8'(busy), 8'd0);
      chk("arst_disp", 8'({disp3, disp2} | {disp1, disp0}), 8'd0);
      chk("arst_ovf", 8'(overflow), 8'd0);
`ifdef FREQ_GATE_CTRL_AUTORANGE_EN
      chk("arst_range", 8'(range), 8'd0);
`endif
      sb.delete();
      exp_range = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_busy", 8'(busy), 8'd0);
      measure(4'd2, 4'd0, 4'd4, 4'd8, 0);

      chk("sb_empty", 8'(sb.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
